// File: rtl/regfile.sv
// regfile: 32 x 32-bit general-purpose register file for the MIPS32 pipeline.
// Two combinational read ports with WB->ID write-through bypass, one write
// port, a registered debug read port, and a post-reset clear sequencer that
// zeroes registers 1..31 one per cycle through the single write port.
module regfile #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready_o,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re1_i,
    input  logic [$clog2(DEPTH)-1:0] raddr1_i,
    output logic [WIDTH-1:0]         rdata1_o,
    input  logic                     re2_i,
    input  logic [$clog2(DEPTH)-1:0] raddr2_i,
    output logic [WIDTH-1:0]         rdata2_o,
    input  logic                     dbg_req_i,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr_i,
    output logic                     dbg_ack_o,
    output logic [WIDTH-1:0]         dbg_data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state;
    logic [AW-1:0]   ptr;
    logic [WIDTH-1:0] regs [DEPTH];

    // Shared read path: zero while in reset/clear, disabled or r0; bypass next.
    function automatic logic [WIDTH-1:0] read_port(input logic en,
                                                   input logic [AW-1:0] addr);
        if (!rst || state == CLEAR || !en || addr == '0)
            return '0;
        else if (we_i && waddr_i == addr)
            return wdata_i;
        else
            return regs[addr];
    endfunction

    // Clear sequencer: walk ptr from 1 to the last register, then enter RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= CLEAR;
            ptr     <= AW'(1);
            ready_o <= 1'b0;
        end else if (state == CLEAR) begin
            ptr <= ptr + AW'(1);
            if (ptr == LAST_ADDR) begin
                state   <= RUN;
                ready_o <= 1'b1;
            end
        end
    end

    // Single write port: the sequencer owns it in CLEAR, WB owns it in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == CLEAR)
                regs[ptr] <= '0;
            else if (we_i && waddr_i != '0)
                regs[waddr_i] <= wdata_i;
        end
    end

    // Combinational ID-stage read ports.
    always_comb begin
        rdata1_o = read_port(re1_i, raddr1_i);
        rdata2_o = read_port(re2_i, raddr2_i);
    end

    // Debug port: one-cycle registered read, data holds when no request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dbg_ack_o  <= 1'b0;
            dbg_data_o <= '0;
        end else if (dbg_req_i) begin
            dbg_ack_o  <= 1'b1;
            dbg_data_o <= read_port(1'b1, dbg_addr_i);
        end else begin
            dbg_ack_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed, table-driven self-checking bench for regfile.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        ready_o;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic        re1_i;
    logic [4:0]  raddr1_i;
    logic [31:0] rdata1_o;
    logic        re2_i;
    logic [4:0]  raddr2_i;
    logic [31:0] rdata2_o;
    logic        dbg_req_i;
    logic [4:0]  dbg_addr_i;
    logic        dbg_ack_o;
    logic [31:0] dbg_data_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  raddr1;
        logic        re2;
        logic [4:0]  raddr2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [13];

    regfile #(.DEPTH(32), .WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ready_o    (ready_o),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .re1_i      (re1_i),
        .raddr1_i   (raddr1_i),
        .rdata1_o   (rdata1_o),
        .re2_i      (re2_i),
        .raddr2_i   (raddr2_i),
        .rdata2_o   (rdata2_o),
        .dbg_req_i  (dbg_req_i),
        .dbg_addr_i (dbg_addr_i),
        .dbg_ack_o  (dbg_ack_o),
        .dbg_data_o (dbg_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        we_i     = v.we;
        waddr_i  = v.waddr;
        wdata_i  = v.wdata;
        re1_i    = v.re1;
        raddr1_i = v.raddr1;
        re2_i    = v.re2;
        raddr2_i = v.raddr2;
    endtask

    task automatic idle_inputs();
        we_i = 0; waddr_i = 0; wdata_i = 0;
        re1_i = 0; raddr1_i = 0; re2_i = 0; raddr2_i = 0;
        dbg_req_i = 0; dbg_addr_i = 0;
    endtask

    initial begin
        //          we waddr wdata          re1 ra1 re2 ra2 exp1           exp2
        vecs[0]  = '{1, 5,  32'h1234_5678, 1, 5,  1, 5,  32'h1234_5678, 32'h1234_5678};
        vecs[1]  = '{0, 0,  32'h0,         1, 5,  1, 5,  32'h1234_5678, 32'h1234_5678};
        vecs[2]  = '{0, 0,  32'h0,         0, 5,  1, 5,  32'h0,         32'h1234_5678};
        vecs[3]  = '{1, 0,  32'hFFFF_FFFF, 1, 0,  1, 0,  32'h0,         32'h0};
        vecs[4]  = '{0, 0,  32'h0,         1, 0,  1, 0,  32'h0,         32'h0};
        vecs[5]  = '{1, 7,  32'h0000_0001, 1, 5,  1, 7,  32'h1234_5678, 32'h0000_0001};
        vecs[6]  = '{1, 7,  32'hDEAD_BEEF, 1, 7,  1, 7,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[7]  = '{1, 9,  32'hCAFE_F00D, 1, 7,  1, 9,  32'hDEAD_BEEF, 32'hCAFE_F00D};
        vecs[8]  = '{0, 0,  32'h0,         1, 9,  1, 3,  32'hCAFE_F00D, 32'h0};
        vecs[9]  = '{1, 9,  32'h0,         1, 9,  1, 5,  32'h0,         32'h1234_5678};
        vecs[10] = '{0, 0,  32'h0,         1, 9,  1, 31, 32'h0,         32'h0};
        vecs[11] = '{1, 31, 32'h8000_0001, 1, 31, 0, 31, 32'h8000_0001, 32'h0};
        vecs[12] = '{0, 0,  32'h0,         1, 31, 1, 1,  32'h8000_0001, 32'h0};

        idle_inputs();
        rst = 1'b0;

        // Reset held for 3 edges; outputs at reset values, reads forced to 0.
        repeat (3) tick();
        re1_i = 1; raddr1_i = 5;
        #1;
        checkOutput("reset_ready", {31'b0, ready_o}, 32'h0);
        checkOutput("reset_dbg_ack", {31'b0, dbg_ack_o}, 32'h0);
        checkOutput("reset_dbg_data", dbg_data_o, 32'h0);
        checkOutput("reset_rdata1", rdata1_o, 32'h0);
        re1_i = 0; raddr1_i = 0;
        rst = 1'b1;

        // Partial clear, then reset on what would be clear edge 20.
        for (int i = 1; i <= 19; i++) begin
            tick();
            checkOutput($sformatf("partial_clear_ready_%0d", i), {31'b0, ready_o}, 32'h0);
        end
        rst = 1'b0;
        tick();
        checkOutput("midclear_reset_ready", {31'b0, ready_o}, 32'h0);
        rst = 1'b1;

        // Full clear with a write to r3 presented throughout (must be dropped).
        we_i = 1; waddr_i = 3; wdata_i = 32'hA5A5_A5A5;
        re1_i = 1; raddr1_i = 3;
        for (int i = 1; i <= 31; i++) begin
            #1;
            checkOutput($sformatf("clear_read_zero_%0d", i), rdata1_o, 32'h0);
            tick();
            checkOutput($sformatf("clear_ready_edge_%0d", i), {31'b0, ready_o},
                        (i == 31) ? 32'h1 : 32'h0);
        end
        idle_inputs();

        // Debug sweep: every register reads zero after the clear.
        for (int a = 1; a <= 31; a++) begin
            dbg_req_i = 1; dbg_addr_i = 5'(a);
            tick();
            checkOutput($sformatf("dbg_sweep_ack_r%0d", a), {31'b0, dbg_ack_o}, 32'h1);
            checkOutput($sformatf("dbg_sweep_data_r%0d", a), dbg_data_o, 32'h0);
        end
        dbg_req_i = 0;

        // Table-driven read/write/bypass vectors.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_rdata1", i), rdata1_o, vecs[i].exp1);
            checkOutput($sformatf("vec%0d_rdata2", i), rdata2_o, vecs[i].exp2);
            tick();
        end
        idle_inputs();

        // Debug handshake held for 3 cycles: r5, r7, r0.
        dbg_req_i = 1; dbg_addr_i = 5;
        tick();
        checkOutput("dbg_hs_ack0", {31'b0, dbg_ack_o}, 32'h1);
        checkOutput("dbg_hs_data0", dbg_data_o, 32'h1234_5678);
        dbg_addr_i = 7;
        tick();
        checkOutput("dbg_hs_ack1", {31'b0, dbg_ack_o}, 32'h1);
        checkOutput("dbg_hs_data1", dbg_data_o, 32'hDEAD_BEEF);
        dbg_addr_i = 0;
        tick();
        checkOutput("dbg_hs_ack2", {31'b0, dbg_ack_o}, 32'h1);
        checkOutput("dbg_hs_data2", dbg_data_o, 32'h0);
        dbg_req_i = 0;
        tick();
        checkOutput("dbg_hs_ack_drop", {31'b0, dbg_ack_o}, 32'h0);

        // Same-cycle write and debug read return the new data, then hold.
        dbg_req_i = 1; dbg_addr_i = 12;
        we_i = 1; waddr_i = 12; wdata_i = 32'h0BAD_C0DE;
        tick();
        checkOutput("dbg_bypass_ack", {31'b0, dbg_ack_o}, 32'h1);
        checkOutput("dbg_bypass_data", dbg_data_o, 32'h0BAD_C0DE);
        idle_inputs();
        tick();
        checkOutput("dbg_hold_ack", {31'b0, dbg_ack_o}, 32'h0);
        checkOutput("dbg_hold_data", dbg_data_o, 32'h0BAD_C0DE);

        // Reset mid-run: data re-cleared, reads are zero during reset/clear.
        rst = 1'b0;
        re1_i = 1; raddr1_i = 5;
        #1;
        checkOutput("run_reset_rdata1", rdata1_o, 32'h0);
        tick();
        checkOutput("run_reset_ready", {31'b0, ready_o}, 32'h0);
        checkOutput("run_reset_dbg_data", dbg_data_o, 32'h0);
        rst = 1'b1;
        dbg_req_i = 1; dbg_addr_i = 7;
        tick();
        checkOutput("clear_dbg_ack", {31'b0, dbg_ack_o}, 32'h1);
        checkOutput("clear_dbg_data", dbg_data_o, 32'h0);
        dbg_req_i = 0;
        repeat (29) tick();
        checkOutput("reclear_ready_edge30", {31'b0, ready_o}, 32'h0);
        tick();
        checkOutput("reclear_ready_edge31", {31'b0, ready_o}, 32'h1);
        re2_i = 1; raddr2_i = 31;
        #1;
        checkOutput("reclear_r5", rdata1_o, 32'h0);
        checkOutput("reclear_r31", rdata2_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the five-stage MIPS32 pipeline: 32 × 32-bit registers with two combinational read ports serving the ID stage, one write port driven by the WB stage, and a registered debug read port with a request/acknowledge handshake. After every reset, a clear sequencer zeroes registers 1–31 one per cycle, so the array maps onto single-write-port storage. `ready_o` gates the pipeline until the clear completes.

## Interface
- DEPTH, 32: number of registers; fixed, and `log2(DEPTH)` = 5 sets the address width.
- WIDTH, 32: register width in bits.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- ready_o  out  1  1 = clear sequence done, and register file is usable.
- we_i  in  1  write enable from WB.
- waddr_i  in  5  write address.
- wdata_i  in  32  write data.
- re1_i  in  1  read-port-1 enable from ID (`reg1_read`).
- raddr1_i  in  5  read-port-1 address.
- rdata1_o  out  32  read-port-1 data (combinational).
- re2_i  in  1  read-port-2 enable.
- raddr2_i  in  5  read-port-2 address.
- rdata2_o  out  32  read-port-2 data (combinational).
- dbg_req_i  in  1  debug read request.
- dbg_addr_i  in  5  debug read address.
- dbg_ack_o  out  1  debug data valid (registered).
- dbg_data_o  out  32  debug read data (registered).

## Operation
- **Register 0** is hardwired to zero.
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0.
- **Clear sequencer** (2 states: CLEAR, RUN).
  - Reset puts it in CLEAR with ptr = 1.
  - In CLEAR, each edge with rst = 1 writes 0 to regs[ptr] and increments ptr.
  - On the edge that clears ptr = 31, the state becomes RUN and ready_o becomes 1.
  - RUN is held until the next reset.
- **Write:** at an edge with rst = 1, state RUN, we_i = 1 and waddr_i ≠ 0, regs[waddr_i] ← wdata_i.
  - Writes presented in CLEAR are dropped; the sequencer is not disturbed.
- **Read port n** (combinational). Priority order:
  - 0 if rst = 0, or state is CLEAR, or re_n = 0, or raddr_n = 0;
  - else wdata_i if we_i = 1 and waddr_i = raddr_n (write-through bypass, WB→ID same cycle);
  - else regs[raddr_n].
  - Both ports may address the same register simultaneously; both return the same value.
- **Debug port:**
  - Each edge with rst = 1 and dbg_req_i = 1 sets dbg_ack_o ← 1 and dbg_data_o ← the read-port value for dbg_addr_i in that cycle, with enable forced to 1. This includes the bypass, and the value is 0 while in CLEAR.
  - Otherwise dbg_ack_o ← 0 and dbg_data_o holds its value.
  - A held request produces a back-to-back ack every cycle.

## Timing
- **Reset values** (edge with rst = 0): ready_o = 0, dbg_ack_o = 0, dbg_data_o = 0, state CLEAR, ptr = 1.
  - rdata1_o and rdata2_o read 0 combinationally while rst = 0.
- **Clear latency:** ready_o rises after the 31st rising edge following reset deassertion.
- **Reset mid-clear or mid-run:** the sequencer restarts at ptr = 1, and previously written data is re-cleared.
- **Write-to-read latency:**
  - 0 cycles via the bypass in the write cycle;
  - from the array on every later cycle.
- **Debug latency:** 1 cycle from request edge to ack.
  - A write and a debug request to the same address in the same cycle return the new data.
- **ptr:** 5-bit; never wraps in RUN, because ptr is not incremented there.

## Test plan
- **Reset and clear:** hold rst = 0 for 3 cycles, then release.
  - ready_o = 0 for exactly 31 edges, then 1.
  - A debug read of each address 1–31 afterwards returns 0.
- **Write/read:** write 0x1234_5678 to r5, then read r5 on port 1 and port 2 one cycle later.
  - Both ports return 0x1234_5678.
  - With re1_i = 0, port 1 returns 0.
- **r0 protection:** write 0xFFFF_FFFF to r0 with both ports reading r0 in the same cycle and the next cycle.
  - All reads return 0.
- **Bypass:** write 0xDEAD_BEEF to r7 while port 1 reads r7 in the same cycle, with r7 previously 0x1.
  - rdata1_o = 0xDEAD_BEEF combinationally in that cycle.
- **Clear interaction:**
  - A write of 0xA5A5_A5A5 to r3 during CLEAR is dropped; after ready_o = 1, r3 reads 0.
  - Asserting rst = 0 at clear edge 20 restarts the full 31-edge count.
- **Debug handshake:** hold dbg_req_i for 3 cycles with addresses 5, 7, 0.
  - dbg_ack_o is high for 3 consecutive cycles, each one edge later than its request, with data 0x1234_5678, 0xDEAD_BEEF, 0.
  - dbg_ack_o drops the cycle after the request drops.
